uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 16x-oversampling asynchronous UART receiver for the UART peripheral.
- Sits directly upstream of the UART register interface.
- Consumes the raw uart_rxd pin and delivers received bytes plus status flags.
- The register interface reads the data, acknowledges it and clears the error flags.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on uart_rxd (minimum 2).
- DIV_W, 16, width of the baud divisor.

Ports:
- mclk  input  1  main system clock.
- puc_rst  input  1  reset, asynchronous, active-high.
- uart_rxd  input  1  serial receive pin; asynchronous; idle high.
- rx_en  input  1  receiver enable from the control register.
- baud_div  input  DIV_W  oversample tick divisor; tick period = baud_div+1 mclk cycles.
- rd_ack  input  1  one-cycle pulse; register interface has read rx_data.
- err_clr  input  1  one-cycle pulse; clears rx_ovf_err, rx_frm_err and rx_par_err.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_busy  output  1  FSM not in IDLE.
- rx_ovf_err  output  1  sticky overrun flag.
- rx_frm_err  output  1  sticky framing-error flag.
- rx_par_err  output  1  sticky parity-error flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, synchroniser flops 1.
- Reset is fully asynchronous and may assert mid-frame; the frame is discarded.
- Sync: uart_rxd passes through SYNC_STAGES flops; rxd_s is the last stage.
- Tick generator:
  - Counter runs 0..baud_div, emits tick when equal to baud_div, then reloads 0.
  - baud_div=0 gives a tick every cycle; bit period = 16*(baud_div+1) mclk.
  - Counter is held at 0 while in IDLE, so phase aligns to start detection.
  - A change to baud_div takes effect on the next wrap.
- Sampling: sub-bit counter 0..15 advances on each tick; rxd_s is sampled at sub-counts 7, 8 and 9; the bit value is the majority of the three, decided at sub-count 9.
- FSM:
  - IDLE: rx_en=1 and rxd_s=0 -> START, counters cleared.
  - START: if the majority is 1 at sub-count 9 -> IDLE (glitch rejected), else continue. Leave for DATA at sub-count 15.
  - DATA: 8 bits shifted in LSB first. Leave at sub-count 15 of bit 7, to PARITY if enabled, else STOP.
  - STOP: at sub-count 9, load rx_data, set rx_valid; a majority of 0 also sets rx_frm_err. Go to IDLE in the same cycle, so the next start edge can be detected immediately.
- Byte completion:
  - Completion with rx_valid=1 and no rd_ack in the same cycle -> rx_ovf_err=1 and rx_data is overwritten.
  - Completion and rd_ack in the same cycle -> new data loaded, rx_valid stays 1, no overrun.
  - rd_ack with no completion -> rx_valid=0 on the next cycle.
- err_clr: clears all three error flags. If an error-setting event coincides with err_clr, the set wins.
- rx_en=0: FSM forced to IDLE and counters cleared within 1 cycle. rx_data, rx_valid and the flags hold their values.
- rx_busy = (state != IDLE), registered.
- Latency: rx_valid rises on the cycle after the stop-bit sub-count-9 tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is added between DATA and STOP, with one extra bit time.
  - The sampled bit is compared against even parity over the 8 data bits.
  - On a mismatch, rx_par_err is set at stop-bit completion, alongside the load.
- Undefined: PARITY state is absent and rx_par_err is a constant 0.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - OVERSAMPLE=16 and sample indices 7/8/9.
  - Data width 8.
  - Macro guards.
- One sub-module, uart_baud_gen: divisor counter plus tick output, with a hold input. It is reused later by uart_tx.

Test Plan:
- baud_div=0, send 0xA5 8N1 (16-cycle bits) -> rx_data=0xA5, rx_valid=1 about 152+SYNC_STAGES cycles after the start edge; rx_busy low afterwards.
- baud_div=3, low pulse of 20 cycles on an idle line (shorter than the majority window at sub-counts 7-9) -> returns to IDLE; rx_valid stays 0, no flags set.
- Send 0x3C with stop bit 0 -> rx_data=0x3C, rx_valid=1, rx_frm_err=1; then err_clr pulse -> rx_frm_err=0.
- Send 0x11 then 0x22 without rd_ack -> rx_data=0x22, rx_ovf_err=1. Repeat with rd_ack pulsed on the 0x22 completion cycle -> rx_ovf_err=0, rx_valid=1.
- Drop rx_en at bit 3 of a frame -> rx_busy=0 within 1 cycle, rx_data unchanged. Assert puc_rst mid-frame -> all outputs 0 immediately.
- UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 -> rx_par_err=1. Send 0x07 with parity bit 1 -> rx_par_err=0, rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver FSM encoding,
// oversampling constants and the data width.
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SUB_W      = $clog2(OVERSAMPLE);
  localparam int DATA_W     = 8;

  typedef logic [SUB_W-1:0] sub_t;

  // Sub-bit positions of the three majority samples and the last sub-count.
  localparam sub_t SAMPLE_A = sub_t'(7);
  localparam sub_t SAMPLE_B = sub_t'(8);
  localparam sub_t SAMPLE_C = sub_t'(9);
  localparam sub_t LAST_SUB = sub_t'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: a divisor counter that fires one tick every
// div+1 cycles. While hold is high the counter sits at 0 so the first tick
// phase lines up with whatever released the hold. A new divisor is picked up
// only when the counter wraps (or while held).
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  // Next-count and divisor reload logic; tick is the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    tick  = !hold && (cnt_q == div_q);
    if (hold || tick) begin
      cnt_d = '0;
      div_d = div;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and latched divisor registers.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: synchroniser, majority-vote sampling,
// byte assembly and sticky status flags for the register interface.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 16
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             uart_rxd,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rd_ack,
  input  logic             err_clr,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_busy,
  output logic             rx_ovf_err,
  output logic             rx_frm_err,
  output logic             rx_par_err
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_s;
  rx_state_e              state_q, state_d;
  sub_t                   sub_q, sub_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   s7_q, s7_d, s8_q, s8_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;
  logic                   frm_q, frm_d;
  logic                   tick, hold, maj, done, frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   par_bad_q, par_bad_d;
`endif

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign hold  = (state_q == ST_IDLE) || !rx_en;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .hold    (hold),
    .div     (baud_div),
    .tick    (tick)
  );

  // Receive sequencing, sampling and flag update for the next cycle.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], uart_rxd};
    state_d   = state_q;
    sub_d     = sub_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    frm_d     = frm_q;
    done      = 1'b0;
    frame_bad = 1'b0;
    maj       = majority3(s7_q, s8_q, rxd_s);
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    par_bad_d = par_bad_q;
`endif

    if (!rx_en) begin
      state_d = ST_IDLE;
      sub_d   = '0;
      bit_d   = '0;
    end else if (state_q == ST_IDLE) begin
      sub_d = '0;
      bit_d = '0;
      if (!rxd_s) state_d = ST_START;
    end else if (tick) begin
      if (sub_q == SAMPLE_A) s7_d = rxd_s;
      if (sub_q == SAMPLE_B) s8_d = rxd_s;
      sub_d = sub_q + 1'b1;
      case (state_q)
        ST_START: begin
          if (sub_q == SAMPLE_C && maj) begin
            state_d = ST_IDLE;
            sub_d   = '0;
          end else if (sub_q == LAST_SUB) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (sub_q == SAMPLE_C) shift_d = {maj, shift_q[DATA_W-1:1]};
          if (sub_q == LAST_SUB) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (sub_q == SAMPLE_C) par_bad_d = maj ^ (^shift_q);
          if (sub_q == LAST_SUB) state_d = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (sub_q == SAMPLE_C) begin
            done      = 1'b1;
            frame_bad = !maj;
            state_d   = ST_IDLE;
            sub_d     = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          sub_d   = '0;
        end
      endcase
    end

    if (err_clr) begin
      ovf_d = 1'b0;
      frm_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d = 1'b0;
`endif
    end

    if (done) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !rd_ack) ovf_d = 1'b1;
      if (frame_bad) frm_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      if (par_bad_q) par_d = 1'b1;
`endif
    end else if (rd_ack) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and flag registers.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      sync_q    <= '1;
      state_q   <= ST_IDLE;
      sub_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      s7_q      <= 1'b0;
      s8_q      <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      frm_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      sub_q     <= sub_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      frm_q     <= frm_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_busy    = busy_q;
  assign rx_ovf_err = ovf_q;
  assign rx_frm_err = frm_q;
`ifdef UART_RX_PARITY_EN
  assign rx_par_err = par_q;
`else
  assign rx_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a table of frames, randomised frames
// checked against a frame-level reference model, and hand-written
// sequences for glitch rejection, overrun, enable drop and reset.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef bit bitq_t[$];

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         parBad;
    int         div;
    logic [7:0] expData;
    bit         expFrm;
    bit         expPar;
  } vec_t;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        uart_rxd;
  logic        rx_en;
  logic [15:0] baud_div;
  logic        rd_ack;
  logic        err_clr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_busy;
  logic        rx_ovf_err;
  logic        rx_frm_err;
  logic        rx_par_err;

  int nChecks = 0;
  int nFails  = 0;

  vec_t vecs[8];

  uart_rx #(.SYNC_STAGES(2), .DIV_W(16)) dut (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .uart_rxd   (uart_rxd),
    .rx_en      (rx_en),
    .baud_div   (baud_div),
    .rd_ack     (rd_ack),
    .err_clr    (err_clr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .rx_ovf_err (rx_ovf_err),
    .rx_frm_err (rx_frm_err),
    .rx_par_err (rx_par_err)
  );

  // 100 MHz main clock.
  always #5 mclk = ~mclk;

  // Global time limit so the run always ends.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Serial frame as a list of line levels, start bit first.
  function automatic bitq_t buildFrame(input logic [7:0] d, input bit stop, input bit parBad);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (PAR_EN) q.push_back((^d) ^ parBad);
    q.push_back(stop);
    return q;
  endfunction

  // Reference model: what a receiver must report for a given line frame.
  task automatic modelDecode(input bitq_t q, output logic [7:0] d, output bit frm, output bit par);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = q[i+1];
      if (q[i+1]) ones++;
    end
    frm = (q[q.size()-1] == 1'b0);
    par = 1'b0;
    if (PAR_EN) par = (((ones + int'(q[9])) % 2) != 0);
  endtask

  // Drive the first nBits bits of a frame, each 16*(div+1) cycles long.
  task automatic driveFrame(input logic [7:0] d, input bit stop, input bit parBad, input int div, input int nBits);
    bitq_t q;
    q = buildFrame(d, stop, parBad);
    for (int i = 0; i < nBits && i < q.size(); i++) begin
      uart_rxd = q[i];
      repeat (16 * (div + 1)) @(negedge mclk);
    end
    if (nBits >= q.size()) uart_rxd = 1'b1;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (rx_busy === 1'b1 && n < 3000) begin
      @(negedge mclk);
      n++;
    end
    checkOutput(name, {31'd0, rx_busy}, 32'd0);
  endtask

  task automatic ackAndClear();
    rd_ack  = 1'b1;
    err_clr = 1'b1;
    @(negedge mclk);
    rd_ack  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit stop, input bit parBad, input int div);
    baud_div = 16'(div);
    driveFrame(d, stop, parBad, div, 99);
    repeat (16 * (div + 1)) @(negedge mclk);
    waitIdle("busy_after_frame");
  endtask

  initial begin
    logic [7:0] rd;
    bit         rf, rp;
    int         ackAt;
    puc_rst  = 1'b1;
    uart_rxd = 1'b1;
    rx_en    = 1'b1;
    baud_div = 16'd0;
    rd_ack   = 1'b0;
    err_clr  = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 2, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 3, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 0, 8'h07, 1'b0, PAR_EN};
    vecs[5] = '{8'h07, 1'b1, 1'b0, 0, 8'h07, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{8'h5A, 1'b0, 1'b1, 2, 8'h5A, 1'b1, PAR_EN};

    repeat (3) @(negedge mclk);
    checkOutput("rst_data",  {24'd0, rx_data}, 32'd0);
    checkOutput("rst_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("rst_busy",  {31'd0, rx_busy}, 32'd0);
    checkOutput("rst_flags", {29'd0, rx_ovf_err, rx_frm_err, rx_par_err}, 32'd0);
    puc_rst = 1'b0;
    repeat (3) @(negedge mclk);

    // Table of frames.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stop, vecs[i].parBad, vecs[i].div);
      checkOutput("vec_data",  {24'd0, rx_data}, {24'd0, vecs[i].expData});
      checkOutput("vec_valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("vec_frm",   {31'd0, rx_frm_err}, {31'd0, vecs[i].expFrm});
      checkOutput("vec_par",   {31'd0, rx_par_err}, {31'd0, vecs[i].expPar});
      checkOutput("vec_ovf",   {31'd0, rx_ovf_err}, 32'd0);
      ackAndClear();
      checkOutput("vec_ack_valid", {31'd0, rx_valid}, 32'd0);
      checkOutput("vec_clr_flags", {29'd0, rx_ovf_err, rx_frm_err, rx_par_err}, 32'd0);
    end

    // Randomised frames against the reference model.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      bit         st, pb;
      int         dv;
      d  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      pb = ($urandom_range(0, 3) == 0);
      dv = $urandom_range(0, 2);
      modelDecode(buildFrame(d, st, pb), rd, rf, rp);
      applyStimulus(d, st, pb, dv);
      checkOutput("rnd_data",  {24'd0, rx_data}, {24'd0, rd});
      checkOutput("rnd_valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("rnd_frm",   {31'd0, rx_frm_err}, {31'd0, rf});
      checkOutput("rnd_par",   {31'd0, rx_par_err}, {31'd0, rp});
      ackAndClear();
      checkOutput("rnd_ack_valid", {31'd0, rx_valid}, 32'd0);
    end

    // Short low glitch on an idle line is rejected.
    baud_div = 16'd3;
    uart_rxd = 1'b0;
    repeat (10) @(negedge mclk);
    checkOutput("glitch_busy", {31'd0, rx_busy}, 32'd1);
    repeat (10) @(negedge mclk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge mclk);
    waitIdle("glitch_idle");
    checkOutput("glitch_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("glitch_flags", {29'd0, rx_ovf_err, rx_frm_err, rx_par_err}, 32'd0);

    // Framing error then explicit clear.
    applyStimulus(8'h3C, 1'b0, 1'b0, 0);
    checkOutput("frm_set", {31'd0, rx_frm_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge mclk);
    err_clr = 1'b0;
    checkOutput("frm_clr", {31'd0, rx_frm_err}, 32'd0);
    checkOutput("frm_clr_valid", {31'd0, rx_valid}, 32'd1);
    rd_ack = 1'b1;
    @(negedge mclk);
    rd_ack = 1'b0;

    // Overrun: second byte arrives before the first is read.
    applyStimulus(8'h11, 1'b1, 1'b0, 0);
    applyStimulus(8'h22, 1'b1, 1'b0, 0);
    checkOutput("ovf_data", {24'd0, rx_data}, 32'h22);
    checkOutput("ovf_set",  {31'd0, rx_ovf_err}, 32'd1);
    checkOutput("ovf_valid", {31'd0, rx_valid}, 32'd1);
    ackAndClear();
    checkOutput("ovf_clr", {31'd0, rx_ovf_err}, 32'd0);

    // Read acknowledged on the very completion cycle: no overrun.
    applyStimulus(8'h11, 1'b1, 1'b0, 0);
    checkOutput("ack_pre_valid", {31'd0, rx_valid}, 32'd1);
    ackAt = 3 + (153 + (PAR_EN ? 16 : 0));
    fork
      driveFrame(8'h22, 1'b1, 1'b0, 0, 99);
      begin
        repeat (ackAt) @(negedge mclk);
        checkOutput("ack_pre_data", {24'd0, rx_data}, 32'h11);
        rd_ack = 1'b1;
        @(negedge mclk);
        rd_ack = 1'b0;
        checkOutput("ack_same_data", {24'd0, rx_data}, 32'h22);
      end
    join
    waitIdle("ack_idle");
    checkOutput("ack_ovf",   {31'd0, rx_ovf_err}, 32'd0);
    checkOutput("ack_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("ack_data",  {24'd0, rx_data}, 32'h22);

    // Receiver disabled part-way through bit 3.
    driveFrame(8'h5A, 1'b1, 1'b0, 0, 4);
    uart_rxd = 1'b1;
    repeat (8) @(negedge mclk);
    checkOutput("en_busy_pre", {31'd0, rx_busy}, 32'd1);
    rx_en = 1'b0;
    @(negedge mclk);
    checkOutput("en_busy", {31'd0, rx_busy}, 32'd0);
    checkOutput("en_data", {24'd0, rx_data}, 32'h22);
    checkOutput("en_valid", {31'd0, rx_valid}, 32'd1);
    repeat (5) @(negedge mclk);
    rx_en = 1'b1;
    repeat (40) @(negedge mclk);
    checkOutput("en_resume_busy", {31'd0, rx_busy}, 32'd0);

    // Reset asserted mid-frame clears everything at once.
    driveFrame(8'h5A, 1'b1, 1'b0, 0, 5);
    checkOutput("rst_mid_busy_pre", {31'd0, rx_busy}, 32'd1);
    puc_rst = 1'b1;
    #1;
    checkOutput("rst_mid_data",  {24'd0, rx_data}, 32'd0);
    checkOutput("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("rst_mid_busy",  {31'd0, rx_busy}, 32'd0);
    uart_rxd = 1'b1;
    @(negedge mclk);
    puc_rst = 1'b0;
    repeat (3) @(negedge mclk);

    // Clean frame after reset.
    applyStimulus(8'h96, 1'b1, 1'b0, 1);
    checkOutput("post_rst_data",  {24'd0, rx_data}, 32'h96);
    checkOutput("post_rst_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("post_rst_flags", {29'd0, rx_ovf_err, rx_frm_err, rx_par_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
